// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared FSM state type and table-depth helper for prog_lut.
package prog_lut_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  function automatic int depth(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/lut_table.sv
// lut_table: serially loaded truth-table shift register with a combinational read mux.
module lut_table
  import prog_lut_pkg::*;
#(
  parameter int N = 4,
  parameter logic [depth(N)-1:0] INIT = 16'h212F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         shift_bit,
  input  logic [N-1:0] addr,
  output logic         data
);
  logic [depth(N)-1:0] tbl;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tbl <= INIT;
    else if (shift_en) tbl <= {shift_bit, tbl[depth(N)-1:1]};
  end
  assign data = tbl[addr];
endmodule

// File: rtl/prog_lut.sv
// prog_lut: programmable N-input LUT with single evaluations and an exhaustive sweep that counts ones.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int N = 4,
  parameter logic [depth(N)-1:0] INIT = 16'h212F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_bit,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  input  logic         sweep_start,
  output logic         out_valid,
  output logic         s,
  output logic [N-1:0] out_idx,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_count
);
  state_t state, state_nx;
  logic [N-1:0] idx, addr, ev_idx;
  logic [N:0] acc, acc_nx;
  logic rd, ev_valid, ev_s, idle, sweeping, start, eval;
  assign idle = state == IDLE;
  assign sweeping = state == SWEEP;
  assign start = idle && sweep_start && !cfg_en;
  assign eval = idle && in_valid && !cfg_en && !sweep_start;
  assign addr = sweeping ? idx : in_vec;
  assign acc_nx = acc + (N+1)'(rd);
  lut_table #(.N(N), .INIT(INIT)) u_table (
    .clk(clk), .rst(rst), .shift_en(idle && cfg_en), .shift_bit(cfg_bit),
    .addr(addr), .data(rd)
  );
  always_comb begin
    state_nx = idle ? (start ? SWEEP : IDLE) : sweeping ? (&idx ? DONE : SWEEP) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      ev_valid <= 1'b0;
      ev_s <= 1'b0;
      ev_idx <= '0;
      ones_count <= '0;
    end else begin
      state <= state_nx;
      ev_valid <= eval;
      if (eval) begin
        ev_s <= rd;
        ev_idx <= in_vec;
      end
      if (start) begin
        idx <= '0;
        acc <= '0;
      end
      if (sweeping) begin
        idx <= idx + 1'b1;
        acc <= acc_nx;
        if (&idx) ones_count <= acc_nx;
      end
    end
  end
  // Sweep results come straight from the running index so the first SWEEP cycle already shows entry 0.
  assign out_valid = sweeping || ev_valid;
  assign s = sweeping ? rd : ev_s;
  assign out_idx = sweeping ? idx : ev_idx;
  assign busy = !idle;
  assign done = state == DONE;
endmodule
